scsi_slave_term: RTL

SCSI_SLAVE_TERM -- requirements
Module: scsi_slave_term

---
 rtl/a4092_pkg.sv | 15 +
 rtl/sync_ff.sv | 23 ++
 rtl/scsi_slave_term.sv | 123 ++++++++++++
 3 files changed

// File: rtl/a4092_pkg.sv
// Shared types and defaults for the A4092 53C710 slave-access path.
package a4092_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 64;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSterm,
    StLatch,
    StAck,
    StTout
  } slave_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous active-low strobe; resets to the inactive level (1).
module sync_ff #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= (sync_q << 1) | Depth'(d_i);
    end
  end

  assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/scsi_slave_term.sv
// Terminates Zorro III slave cycles to the 53C710: waits for STERM, pulses the read latch,
// drives DTACK, or raises BERR on timeout.
module scsi_slave_term
  import a4092_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic CLKI,
  input  logic IORST_n,
  input  logic FCS_n,
  input  logic slave_cycle,
  input  logic SCSI_AS_n,
  input  logic SCSI_STERM_n,
  input  logic READ,
  output logic DTACK_n,
  output logic BERR_n,
  output logic D_LE,
  output logic slave_busy
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  logic sterm_s, fcs_s;

  sync_ff #(.Depth(SYNC_STAGES)) u_sync_sterm (
    .clk_i (CLKI),
    .rst_ni(IORST_n),
    .d_i   (SCSI_STERM_n),
    .q_o   (sterm_s)
  );

  sync_ff #(.Depth(SYNC_STAGES)) u_sync_fcs (
    .clk_i (CLKI),
    .rst_ni(IORST_n),
    .d_i   (FCS_n),
    .q_o   (fcs_s)
  );

  slave_state_e    state_q;
  logic [CntW-1:0] cnt_q;
  logic            armed_q;
  logic            dtack_n_q, berr_n_q, d_le_q, busy_q;

  // armed_q blocks a restart until IDLE has seen the bus idle (FCS and AS both high),
  // so a stale AS left low after a cycle or a reset cannot retrigger.
  always_ff @(posedge CLKI or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      d_le_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      d_le_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (fcs_s && SCSI_AS_n) armed_q <= 1'b1;
          if (armed_q && !SCSI_AS_n && slave_cycle && !fcs_s) begin
            state_q <= StWaitSterm;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StWaitSterm: begin
          // Priority: abort, then STERM, then timeout.
          if (fcs_s || !slave_cycle) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (!sterm_s) begin
            if (READ) begin
              state_q <= StLatch;
              d_le_q  <= 1'b1;
            end else begin
              state_q   <= StAck;
              dtack_n_q <= 1'b0;
            end
          end else if (cnt_q == CntMax) begin
            state_q  <= StTout;
            berr_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StLatch: begin
          state_q   <= StAck;
          dtack_n_q <= 1'b0;
        end
        StAck: begin
          if (fcs_s) begin
            state_q   <= StIdle;
            dtack_n_q <= 1'b1;
            busy_q    <= 1'b0;
            armed_q   <= 1'b0;
          end
        end
        StTout: begin
          if (fcs_s) begin
            state_q  <= StIdle;
            berr_n_q <= 1'b1;
            busy_q   <= 1'b0;
            armed_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          dtack_n_q <= 1'b1;
          berr_n_q  <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign DTACK_n    = dtack_n_q;
  assign BERR_n     = berr_n_q;
  assign D_LE       = d_le_q;
  assign slave_busy = busy_q;

endmodule
